// File: rtl/fe_fifo_packer_pkg.sv
// Shared front-end FIFO definitions: command encodings, word field layout and small helpers.
package fe_fifo_packer_pkg;

  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'b00;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'b01;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;
  localparam logic [1:0] FE_FIFO_CMD_BAD  = 2'b11;

  localparam int unsigned FE_FIFO_SHORTTIME_LEN   = 3;
  localparam int unsigned FE_FIFO_STATUS_BITS_LEN = 5;
  localparam int unsigned FE_FIFO_DATA_LEN        = 8;
  localparam int unsigned FE_FIFO_CMD_LEN         = 2;

  // Field positions inside an 18-bit FIFO word
  localparam int unsigned FE_FIFO_STATUS_LSB = 8;
  localparam int unsigned FE_FIFO_DATA_LSB   = 0;

  localparam logic [15:0] FE_FIFO_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] fe_fifo_sat_inc(input logic [15:0] value);
    return (value == FE_FIFO_CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fe_fifo_packer_if.sv
// Event bus from the capture FSM into the packer, plus the full indication fed back to it.
interface fe_fifo_packer_if #(
  parameter int unsigned pTIMESTAMP_FULL_WIDTH = 16
);
  logic [1:0]                       I_command;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_time;
  logic [7:0]                       I_data;
  logic [4:0]                       I_status;
  logic                             I_data_wr;
  logic                             O_full_to_capture;

  modport master (
    output I_command, I_time, I_data, I_status, I_data_wr,
    input  O_full_to_capture
  );

  modport slave (
    input  I_command, I_time, I_data, I_status, I_data_wr,
    output O_full_to_capture
  );
endinterface

// File: rtl/fe_fifo_skid2.sv
// Generic 2-entry elastic buffer; head entry is always presented on dout_o.
module fe_fifo_skid2 #(
  parameter int unsigned Width = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] dout_o,
  output logic [1:0]       occ_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_push, do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    do_pop  = pop_i && (occ_q != 2'd0);
    // A push into a full buffer only lands if the head leaves in the same cycle
    do_push = push_i && ((occ_q != 2'd2) || do_pop);
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) head_d = din_i;
          else               tail_d = din_i;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = din_i;
          end else begin
            head_d = tail_q;
            tail_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign dout_o  = head_q;
  assign occ_o   = occ_q;
  assign full_o  = (occ_q == 2'd2);
  assign empty_o = (occ_q == 2'd0);

endmodule

// File: rtl/fe_fifo_packer.sv
// Formats capture-FSM events into FIFO words, buffers two of them and tracks loss statistics.
module fe_fifo_packer
  import fe_fifo_packer_pkg::*;
#(
  parameter int unsigned pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int unsigned pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int unsigned pWORD_WIDTH            = 18
) (
  input  logic                   fe_clk,
  input  logic                   reset_n_i,
  fe_fifo_packer_if.slave        fe_ev,
  input  logic                   I_arm,
  input  logic                   I_flush,
  input  logic                   I_fifo_full,
  output logic [pWORD_WIDTH-1:0] O_fifo_din,
  output logic                   O_fifo_wr,
  output logic [15:0]            O_word_count,
  output logic [15:0]            O_drop_count,
  output logic                   O_overflow,
  output logic                   O_bad_cmd
);

  logic [pWORD_WIDTH-1:0] pack_word;
  logic                   cmd_bad, push_req, pop, accept, drop, arm_rise;
  logic                   buf_full, buf_empty;
  logic [1:0]             buf_occ;

  logic [15:0] word_cnt_q, word_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        ovf_q, ovf_d, bad_q, bad_d, arm_q;

  always_comb begin
    pack_word = '0;
    pack_word[pWORD_WIDTH-1 -: FE_FIFO_CMD_LEN] = fe_ev.I_command;
    if (fe_ev.I_command == FE_FIFO_CMD_TIME) begin
      pack_word[pTIMESTAMP_FULL_WIDTH-1:0] = fe_ev.I_time;
    end else begin
      pack_word[pTIMESTAMP_FULL_WIDTH-1 -: pTIMESTAMP_SHORT_WIDTH] =
        fe_ev.I_time[pTIMESTAMP_SHORT_WIDTH-1:0];
      if (fe_ev.I_command == FE_FIFO_CMD_STAT) begin
        pack_word[FE_FIFO_STATUS_LSB +: FE_FIFO_STATUS_BITS_LEN] = fe_ev.I_status;
      end else begin
        pack_word[FE_FIFO_DATA_LSB +: FE_FIFO_DATA_LEN] = fe_ev.I_data;
      end
    end
  end

  assign cmd_bad  = fe_ev.I_data_wr && (fe_ev.I_command == FE_FIFO_CMD_BAD);
  assign push_req = fe_ev.I_data_wr && !cmd_bad && !I_flush;
  assign pop      = !buf_empty && !I_fifo_full && !I_flush;
  assign accept   = push_req && (!buf_full || pop);
  assign drop     = push_req && buf_full && !pop;
  assign arm_rise = I_arm && !arm_q;

  fe_fifo_skid2 #(
    .Width (pWORD_WIDTH)
  ) u_skid (
    .clk_i   (fe_clk),
    .rst_ni  (reset_n_i),
    .push_i  (accept),
    .din_i   (pack_word),
    .pop_i   (pop),
    .flush_i (I_flush),
    .dout_o  (O_fifo_din),
    .occ_o   (buf_occ),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // Arm clear wins over any increment in the same cycle
  always_comb begin
    word_cnt_d = accept ? fe_fifo_sat_inc(word_cnt_q) : word_cnt_q;
    drop_cnt_d = drop   ? fe_fifo_sat_inc(drop_cnt_q) : drop_cnt_q;
    ovf_d      = ovf_q || drop;
    bad_d      = bad_q || cmd_bad;
    if (arm_rise) begin
      word_cnt_d = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
      bad_d      = 1'b0;
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
      arm_q      <= I_arm;
    end
  end

  assign O_fifo_wr               = pop;
  assign fe_ev.O_full_to_capture = I_fifo_full || (buf_occ == 2'd2);
  assign O_word_count            = word_cnt_q;
  assign O_drop_count            = drop_cnt_q;
  assign O_overflow              = ovf_q;
  assign O_bad_cmd               = bad_q;

endmodule

// File: doc/fe_fifo_packer.md
Name: fe_fifo_packer

Overview:
- Sits directly downstream of the front-end capture FSM, in the fe_clk domain.
- Takes each command/time/data/status event the FSM emits and formats it into one 18-bit FIFO word.
- Buffers words in a 2-entry elastic buffer and writes them into the capture FIFO, honouring FIFO full.
- Upstream has no backpressure, so the block drops words when it cannot buffer them, keeps loss statistics, and reports a full indication back upstream.

Parameters:
- pTIMESTAMP_FULL_WIDTH, 16, width of I_time; TIME words carry I_time[15:0].
- pTIMESTAMP_SHORT_WIDTH, 3, short-time field in DATA/STAT words, taken from I_time[2:0].
- pWORD_WIDTH, 18, FIFO word width; must equal 2 + pTIMESTAMP_FULL_WIDTH.

Ports:
- fe_clk  in  1  front-end clock; all logic on its rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- I_command  in  2  event command: FE_FIFO_CMD_DATA, FE_FIFO_CMD_STAT or FE_FIFO_CMD_TIME.
- I_time  in  pTIMESTAMP_FULL_WIDTH  timestamp accompanying the event.
- I_data  in  8  USB data byte.
- I_status  in  5  front-end status bits.
- I_data_wr  in  1  event strobe, one word per cycle high.
- I_arm  in  1  arm level, already in fe_clk domain; rising edge clears statistics.
- I_flush  in  1  synchronous clear of the buffer contents.
- I_fifo_full  in  1  capture FIFO full.
- O_fifo_din  out  pWORD_WIDTH  FIFO write data.
- O_fifo_wr  out  1  FIFO write enable.
- O_full_to_capture  out  1  fed back to the capture FSM's fifo-full input.
- O_word_count  out  16  words accepted into the buffer since the last arm, saturating.
- O_drop_count  out  16  words dropped since the last arm, saturating.
- O_overflow  out  1  sticky: at least one word dropped since the last arm.
- O_bad_cmd  out  1  sticky: an event with an illegal command was received since the last arm.

Behaviour:
- Word formats (MSB first):
  - DATA: {cmd, I_time[2:0], 5'b0, I_data}.
  - STAT: {cmd, I_time[2:0], I_status, 8'b0}.
  - TIME: {cmd, I_time[15:0]}.
- Command 2'b11 is illegal:
  - the event is not pushed;
  - O_bad_cmd sets;
  - O_drop_count does not increment.
- Packing is combinational at the push point. A push happens when I_data_wr=1, the command is legal and not flushing.
- Buffer: 2 entries, head drives O_fifo_din.
  - O_fifo_wr = !empty && !I_fifo_full (combinational); a pop occurs when O_fifo_wr=1.
- Latency: an event strobed in cycle N with the buffer empty and FIFO not full gives O_fifo_wr=1 in cycle N+1 with the packed word.
- Ordering is strictly FIFO; no reordering or merging.
- Simultaneous push and pop:
  - legal at any occupancy, including 2 (occupancy unchanged);
  - at occupancy 0, push only (no bypass; latency stays 1).
- Overflow: a push at occupancy 2 with no pop that cycle:
  - the word is discarded and the buffer contents are unchanged;
  - O_drop_count increments, saturating at 16'hFFFF;
  - O_overflow sets.
- Word counter: every accepted push increments O_word_count, saturating at 16'hFFFF.
- O_full_to_capture = I_fifo_full || occupancy==2, combinational.
- Arm: rising edge of I_arm (registered copy vs current) clears O_word_count, O_drop_count, O_overflow and O_bad_cmd.
  - Clearing takes priority over an increment in the same cycle; the buffer is not flushed.
- Flush: I_flush=1 empties the buffer next edge and suppresses push and pop that cycle. O_fifo_wr is forced 0 while I_flush=1.
- Reset (asynchronous, any time):
  - buffer empty, O_fifo_wr=0, O_fifo_din=0;
  - all counters and sticky flags 0, arm edge register 0;
  - any word in flight is lost and is not counted as a drop.
- I_fifo_full held high: the buffer fills to 2, then all further events drop. Writes resume in the first cycle I_fifo_full is low.

Decomposition:
- Shared defines, reused from the existing defines file: FE_FIFO_CMD_DATA/STAT/TIME encodings, FE_FIFO_SHORTTIME_LEN, FE_FIFO_STATUS_BITS_LEN, word-field bit positions.
- One sub-module, fe_fifo_skid2: generic 2-entry elastic buffer with push/pop/flush, occupancy and full/empty, parameterised by width.
- Packing, counters and flags stay in the top module.

Test Plan:
- Reset then DATA event (time=5, data=8'hA5), FIFO not full -> next cycle O_fifo_wr=1, O_fifo_din={CMD_DATA,3'd5,5'b0,8'hA5}; word_count=1.
- TIME event time=16'h1234 followed back-to-back by STAT status=5'h13 -> two consecutive writes, {CMD_TIME,16'h1234} then {CMD_STAT,3'd4,5'h13,8'h00}, in order.
- I_fifo_full high, 4 DATA events -> O_full_to_capture=1 after 2 pushes, drop_count=2, overflow=1. Deassert full -> exactly the first two words written in order.
- Occupancy 2, full released in the same cycle a new event arrives -> simultaneous push/pop; no drop, occupancy stays 2.
- Event with command 2'b11 -> no write, bad_cmd=1, drop_count unchanged. Rising I_arm -> all stats 0 even with a concurrent event (that event still written).
- Assert reset_n_i low mid-burst with 2 buffered words -> O_fifo_wr=0 immediately (asynchronous), counters 0; after release, the buffer is empty.
